wb_pending_scoreboard: RTL and testbench

In-order tracker of outstanding register writes from long-latency operations (loads, multi-cycle multiply/divide), placed between decode and writeback. Each issued long-latency op pushes its 5-bit destination address. Writeback pops the oldest entry. Decode-stage source and destination addresses are compared against every pending entry by 5-bit equality compare to raise a stall request.

---
 rtl/wb_scoreboard_pkg.sv | 9 +
 rtl/sb_addr_match.sv | 13 +
 rtl/wb_pending_scoreboard.sv | 80 ++++++++
 tb/tb_wb_pending_scoreboard.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/wb_scoreboard_pkg.sv
// wb_scoreboard_pkg: shared types for the pending-write scoreboard.
package wb_scoreboard_pkg;
    localparam int ADDR_W = 5;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
    } sb_entry_t;
endpackage

// File: rtl/sb_addr_match.sv
// sb_addr_match: one entry-vs-probe equality compare; x0 never matches.
module sb_addr_match
    import wb_scoreboard_pkg::*;
#(
    parameter int W = ADDR_W
) (
    input  logic         valid_i,
    input  logic [W-1:0] entry_i,
    input  logic [W-1:0] probe_i,
    output logic         match_o
);
    assign match_o = valid_i & (probe_i != '0) & (entry_i == probe_i);
endmodule

// File: rtl/wb_pending_scoreboard.sv
// wb_pending_scoreboard: in-order FIFO of pending long-latency destinations with decode hazard detect.
// Define WB_SCOREBOARD_BYPASS_EN to hide the retiring entry from hazard_o (writeback forwarded to decode).
module wb_pending_scoreboard #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = wb_scoreboard_pkg::ADDR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     issue_valid_i,
    input  logic [ADDR_W-1:0]        issue_rd_i,
    output logic                     issue_ready_o,
    input  logic                     wb_valid_i,
    output logic [ADDR_W-1:0]        wb_rd_o,
    input  logic [ADDR_W-1:0]        rs1_i,
    input  logic [ADDR_W-1:0]        rs2_i,
    input  logic [ADDR_W-1:0]        rd_i,
    output logic                     hazard_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;
    logic [DEPTH-1:0]  m_rs1, m_rs2, m_rd;

    assign pop           = wb_valid_i & (count_q != '0);
    assign issue_ready_o = (count_q < CNT_W'(DEPTH)) | wb_valid_i;
    // x0 completes the handshake but is never stored
    assign push          = issue_valid_i & issue_ready_o & (issue_rd_i != '0);
    assign count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign wb_rd_o       = empty_o ? '0 : addr_q[rd_ptr_q];
    assign hazard_o      = |{m_rs1, m_rs2, m_rd};

    // push after pop so a full-buffer push/pop on the same slot leaves it valid
    always_comb begin
        valid_d = valid_q;
        if (pop) valid_d[rd_ptr_q] = 1'b0;
        if (push) valid_d[wr_ptr_q] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            count_q  <= count_d;
            wr_ptr_q <= push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) addr_q[wr_ptr_q] <= issue_rd_i;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
        logic live;
`ifdef WB_SCOREBOARD_BYPASS_EN
        assign live = valid_q[k] & ~(wb_valid_i & (rd_ptr_q == PTR_W'(k)));
`else
        assign live = valid_q[k];
`endif
        sb_addr_match #(.W(ADDR_W)) u_rs1 (.valid_i(live), .entry_i(addr_q[k]), .probe_i(rs1_i), .match_o(m_rs1[k]));
        sb_addr_match #(.W(ADDR_W)) u_rs2 (.valid_i(live), .entry_i(addr_q[k]), .probe_i(rs2_i), .match_o(m_rs2[k]));
        sb_addr_match #(.W(ADDR_W)) u_rd  (.valid_i(live), .entry_i(addr_q[k]), .probe_i(rd_i),  .match_o(m_rd[k]));
    end

    a_wb_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(wb_valid_i && empty_o))
        else $warning("wb_valid_i with no pending entry ignored");
endmodule

// File: tb/tb_wb_pending_scoreboard.sv
// tb_wb_pending_scoreboard: directed and random stimulus against a queue-based reference model.
module tb_wb_pending_scoreboard;
    localparam int DEPTH = 4;
`ifdef WB_SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       issue_valid_i = 1'b0, wb_valid_i = 1'b0;
    logic [4:0] issue_rd_i = '0, rs1_i = '0, rs2_i = '0, rd_i = '0;
    logic       issue_ready_o, hazard_o, empty_o;
    logic [4:0] wb_rd_o;
    logic [2:0] count_o;

    int checks = 0;
    int errors = 0;
    int q[$];

    wb_pending_scoreboard #(.DEPTH(DEPTH), .ADDR_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
        .wb_valid_i(wb_valid_i), .wb_rd_o(wb_rd_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .hazard_o(hazard_o), .count_o(count_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_hazard();
        for (int i = 0; i < q.size(); i++) begin
            if (BYP && wb_valid_i && i == 0) continue;
            if ((rs1_i != 0 && q[i] == int'(rs1_i)) || (rs2_i != 0 && q[i] == int'(rs2_i)) ||
                (rd_i != 0 && q[i] == int'(rd_i))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic set_in(input bit iv, input int ird, input bit wb, input int r1, input int r2, input int rdd);
        issue_valid_i = iv; issue_rd_i = 5'(ird); wb_valid_i = wb;
        rs1_i = 5'(r1); rs2_i = 5'(r2); rd_i = 5'(rdd);
    endtask

    // called at posedge+1: drive, compare combinational outputs, then advance one clock
    task automatic cycle(input bit iv, input int ird, input bit wb, input int r1, input int r2, input int rdd);
        bit rdy, do_pop, do_push;
        set_in(iv, ird, wb, r1, r2, rdd);
        #2;
        rdy = (q.size() < DEPTH) || wb;
        check("ready", issue_ready_o, rdy);
        check("wb_rd", wb_rd_o, q.size() != 0 ? q[0] : 0);
        check("hazard", hazard_o, model_hazard());
        check("count", count_o, q.size());
        check("empty", empty_o, q.size() == 0);
        do_pop  = wb && q.size() > 0;
        do_push = iv && rdy && ird != 0;
        @(posedge clk_i);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(ird);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_ready", issue_ready_o, 1);
        check("rst_wb_rd", wb_rd_o, 0);
        check("rst_hazard", hazard_o, 0);

        // RAW on rd=5 and its release at writeback
        cycle(1, 5, 0, 0, 0, 0);
        set_in(0, 0, 0, 5, 0, 0); #1;
        check("hz_rs1_5", hazard_o, 1);
        cycle(0, 0, 0, 5, 0, 0);
        set_in(0, 0, 1, 5, 0, 0); #1;
        check("hz_retire_5", hazard_o, !BYP);
        cycle(0, 0, 1, 5, 0, 0);
        cycle(0, 0, 0, 5, 0, 0);

        // fill, then push into full with a simultaneous pop
        for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0); #1;
        check("full_ready", issue_ready_o, 0);
        check("full_wb_rd", wb_rd_o, 1);
        cycle(1, 7, 1, 0, 0, 0);
        check("full_swap_count", count_o, 4);
        check("full_swap_wb_rd", wb_rd_o, 2);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 7, 0, 0);

        // x0 is accepted but not tracked
        cycle(1, 0, 0, 0, 0, 0);
        check("x0_count", count_o, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // duplicate destination stays hazardous until the last copy retires
        cycle(1, 9, 0, 0, 0, 0);
        cycle(1, 9, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 9);
        set_in(0, 0, 0, 0, 0, 9); #1;
        check("dup_hazard", hazard_o, 1);
        cycle(0, 0, 0, 0, 0, 9);
        cycle(0, 0, 1, 0, 0, 9);
        cycle(0, 0, 0, 0, 0, 9);

        // pointer wrap with continuous push/pop, then writeback on empty
        cycle(1, 10, 0, 0, 0, 0);
        for (int i = 11; i < 20; i++) cycle(1, i, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        check("wb_empty_count", count_o, 0);
        check("wb_empty_wb_rd", wb_rd_o, 0);

        // random traffic over a small address range to provoke matches
        for (int n = 0; n < 400; n++)
            cycle($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));

        // async reset with entries pending clears outputs without a clock
        while (q.size() > 0) cycle(0, 0, 1, 0, 0, 0);
        cycle(1, 11, 0, 0, 0, 0);
        cycle(1, 12, 0, 0, 0, 0);
        cycle(1, 13, 0, 0, 0, 0);
        set_in(0, 0, 0, 12, 0, 0); #1;
        check("pre_rst_hazard", hazard_o, 1);
        check("pre_rst_count", count_o, 3);
        rst_i = 1'b1;
        #1;
        check("async_rst_count", count_o, 0);
        check("async_rst_hazard", hazard_o, 0);
        check("async_rst_ready", issue_ready_o, 1);
        check("async_rst_empty", empty_o, 1);
        q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        cycle(0, 0, 0, 12, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
